pc_fetch_unit: RTL and testbench

//  Parametrised program-counter unit for the RISC-V fetch stage; replaces the bare PC register.

---
 rtl/pc_fetch_unit.sv | 119 +++++++++++
 tb/tb_pc_fetch_unit.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// ----------------------------------------------------------------------------
// pc_fetch_unit
//   Program-counter unit for the RISC-V fetch stage. It holds the fetch PC and
//   picks the next one by priority: trap, redirect, sequential advance, hold.
//   It drives a valid/ready request to instruction memory and pulses flush to
//   the IF/ID register on every redirect. A misaligned redirect target is
//   turned into a trap, and the offending address is captured.
//
// Ports
//   clk            in   rising-edge clock
//   rst            in   asynchronous active-low reset
//   fetch_en       in   enable fetching (IDLE <-> RUN)
//   stall          in   hazard stall, holds the PC
//   br_taken       in   redirect request from EX
//   br_target      in   redirect target
//   trap           in   exception/interrupt redirect
//   imem_ready     in   imem accepts the current request
//   pc             out  current fetch address (registered)
//   pc_plus4       out  pc + INC (combinational)
//   pc_valid       out  fetch request valid (registered)
//   flush          out  one-cycle pulse after any redirect
//   misalign_err   out  one-cycle pulse after a misaligned br_target
//   misalign_addr  out  last offending target
// ----------------------------------------------------------------------------
module pc_fetch_unit #(
  parameter int                XLEN         = 32,
  parameter logic [XLEN-1:0]   RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0]   TRAP_VECTOR  = 32'h0000_0100,
  parameter int                INC          = 4,
  parameter int                ALIGN_BITS   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_en,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            trap,
  input  logic            imem_ready,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            pc_valid,
  output logic            flush,
  output logic            misalign_err,
  output logic [XLEN-1:0] misalign_addr
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  // Low target bits that must be zero for a legal redirect.
  localparam logic [XLEN-1:0] ALIGN_MASK = (XLEN'(1) << ALIGN_BITS) - XLEN'(1);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            flush_q, flush_d;
  logic            misalign_err_q, misalign_err_d;
  logic [XLEN-1:0] misalign_addr_q, misalign_addr_d;

  logic            tgt_misaligned;

  assign tgt_misaligned = (br_target & ALIGN_MASK) != '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      pc_q            <= RESET_VECTOR;
      flush_q         <= 1'b0;
      misalign_err_q  <= 1'b0;
      misalign_addr_q <= '0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      flush_q         <= flush_d;
      misalign_err_q  <= misalign_err_d;
      misalign_addr_q <= misalign_addr_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    flush_d         = 1'b0;
    misalign_err_d  = 1'b0;
    misalign_addr_d = misalign_addr_q;

    // Entering RUN does not touch the PC, so the first request after
    // enable is whatever the PC already holds.
    unique case (state_q)
      IDLE:    if (fetch_en)  state_d = RUN;
      RUN:     if (!fetch_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Redirects override stall and imem_ready and abandon any pending
    // request; only a transferred request (RUN & ready & !stall) advances.
    if (trap) begin
      pc_d    = TRAP_VECTOR;
      flush_d = 1'b1;
    end else if (br_taken && !tgt_misaligned) begin
      pc_d    = br_target;
      flush_d = 1'b1;
    end else if (br_taken) begin
      pc_d            = TRAP_VECTOR;
      flush_d         = 1'b1;
      misalign_err_d  = 1'b1;
      misalign_addr_d = br_target;
    end else if (state_q == RUN && imem_ready && !stall) begin
      pc_d = pc_q + XLEN'(INC);
    end
  end

  assign pc            = pc_q;
  assign pc_plus4      = pc_q + XLEN'(INC);
  assign pc_valid      = (state_q == RUN);
  assign flush         = flush_q;
  assign misalign_err  = misalign_err_q;
  assign misalign_addr = misalign_addr_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_pc_fetch_unit
//   Directed bench for pc_fetch_unit with hand-computed expected values.
//   Inputs change and outputs are sampled 1 time unit after the rising edge.
// ----------------------------------------------------------------------------
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en, stall, br_taken, trap, imem_ready;
  logic [31:0] br_target;
  logic [31:0] pc, pc_plus4, misalign_addr;
  logic        pc_valid, flush, misalign_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_en     (fetch_en),
    .stall        (stall),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .trap         (trap),
    .imem_ready   (imem_ready),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .pc_valid     (pc_valid),
    .flush        (flush),
    .misalign_err (misalign_err),
    .misalign_addr(misalign_addr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; fetch_en = 1'b0; stall = 1'b0; br_taken = 1'b0;
    trap = 1'b0; imem_ready = 1'b0; br_target = 32'h0;
    #3;
    chk("rst_pc",       pc,            32'h0);
    chk("rst_valid",    32'(pc_valid), 32'h0);
    chk("rst_flush",    32'(flush),    32'h0);
    chk("rst_mis",      32'(misalign_err), 32'h0);
    chk("rst_misaddr",  misalign_addr, 32'h0);
    tick(); tick();
    rst = 1'b1;

    // T1: release, enable at cycle 2, memory always ready
    tick();
    chk("t1_c1_pc",    pc,            32'h0);
    chk("t1_c1_valid", 32'(pc_valid), 32'h0);
    fetch_en = 1'b1; imem_ready = 1'b1;
    tick();
    chk("t1_c2_pc",    pc,            32'h0);
    chk("t1_c2_valid", 32'(pc_valid), 32'h1);
    tick(); chk("t1_pc4", pc, 32'h4);
    tick(); chk("t1_pc8", pc, 32'h8);
    tick(); chk("t1_pcC", pc, 32'hC);
    chk("t1_plus4", pc_plus4, 32'h10);
    tick(); chk("t1_pc10", pc, 32'h10);

    // T2: stall 3 cycles, imem not ready for 2 of them
    stall = 1'b1; imem_ready = 1'b0;
    tick(); chk("t2_hold1", pc, 32'h10);
    tick(); chk("t2_hold2", pc, 32'h10);
    imem_ready = 1'b1;
    tick(); chk("t2_hold3", pc, 32'h10);
    chk("t2_valid", 32'(pc_valid), 32'h1);
    stall = 1'b0;
    tick(); chk("t2_adv", pc, 32'h14);

    // T3: redirect wins over stall
    br_taken = 1'b1; br_target = 32'h200; stall = 1'b1;
    tick();
    chk("t3_pc",    pc,         32'h200);
    chk("t3_flush", 32'(flush), 32'h1);
    chk("t3_plus4", pc_plus4,   32'h204);
    br_taken = 1'b0; stall = 1'b0;
    tick();
    chk("t3_flush_off", 32'(flush), 32'h0);
    chk("t3_pc_next",   pc,         32'h204);

    // T4: trap beats an aligned branch
    trap = 1'b1; br_taken = 1'b1; br_target = 32'h300;
    tick();
    chk("t4_pc",    pc,                32'h100);
    chk("t4_flush", 32'(flush),        32'h1);
    chk("t4_mis",   32'(misalign_err), 32'h0);
    trap = 1'b0; br_taken = 1'b0;
    tick();
    chk("t4_flush_off", 32'(flush), 32'h0);
    chk("t4_pc_next",   pc,         32'h104);

    // T5: misaligned target traps and is captured
    br_taken = 1'b1; br_target = 32'h202;
    tick();
    chk("t5_pc",      pc,                32'h100);
    chk("t5_mis",     32'(misalign_err), 32'h1);
    chk("t5_misaddr", misalign_addr,     32'h202);
    chk("t5_flush",   32'(flush),        32'h1);
    br_taken = 1'b0;
    tick();
    chk("t5_mis_off",  32'(misalign_err), 32'h0);
    chk("t5_misaddr_hold", misalign_addr, 32'h202);
    chk("t5_pc_next",  pc,                32'h104);

    // Back-to-back redirects give back-to-back flush pulses
    br_taken = 1'b1; br_target = 32'h400;
    tick(); chk("b2b_pc1", pc, 32'h400); chk("b2b_fl1", 32'(flush), 32'h1);
    br_target = 32'h500;
    tick(); chk("b2b_pc2", pc, 32'h500); chk("b2b_fl2", 32'(flush), 32'h1);
    br_taken = 1'b0;
    tick(); chk("b2b_fl_off", 32'(flush), 32'h0); chk("b2b_pc3", pc, 32'h504);

    // RUN -> IDLE: last RUN edge still advances, then PC holds in IDLE
    fetch_en = 1'b0;
    tick(); chk("idle_valid", 32'(pc_valid), 32'h0); chk("idle_pc1", pc, 32'h508);
    tick(); chk("idle_pc2", pc, 32'h508);

    // T6: redirect near the top of the address space, then wrap
    fetch_en = 1'b1; br_taken = 1'b1; br_target = 32'hFFFF_FFFC;
    tick();
    chk("t6_pc_top", pc,                32'hFFFF_FFFC);
    chk("t6_plus4",  pc_plus4,          32'h0);
    chk("t6_valid",  32'(pc_valid),     32'h1);
    br_taken = 1'b0;
    tick(); chk("t6_wrap", pc, 32'h0);
    tick(); chk("t6_pc4",  pc, 32'h4);

    // Asynchronous reset mid-run, right after a redirect
    br_taken = 1'b1; br_target = 32'h600;
    tick(); chk("t6_pre_pc", pc, 32'h600); chk("t6_pre_fl", 32'(flush), 32'h1);
    br_taken = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("t6_arst_pc",      pc,            32'h0);
    chk("t6_arst_valid",   32'(pc_valid), 32'h0);
    chk("t6_arst_flush",   32'(flush),    32'h0);
    chk("t6_arst_misaddr", misalign_addr, 32'h0);
    #2 rst = 1'b1;
    // Back in IDLE: first edge only enters RUN, PC stays at the reset vector
    tick();
    chk("t6_post_pc",    pc,            32'h0);
    chk("t6_post_valid", 32'(pc_valid), 32'h1);
    tick();
    chk("t6_post_adv", pc, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
